// File: rtl/ahb_bm_pkg.sv
// Shared AHB bus-matrix definitions: transfer/burst encodings, burst length constants
// and a small index helper used by the output-stage arbiters.
package ahb_bm_pkg;

    typedef enum logic [1:0] {
        TRN_IDLE   = 2'b00,
        TRN_BUSY   = 2'b01,
        TRN_NONSEQ = 2'b10,
        TRN_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BUR_SINGLE = 3'd0,
        BUR_INCR   = 3'd1,
        BUR_WRAP4  = 3'd2,
        BUR_INCR4  = 3'd3,
        BUR_WRAP8  = 3'd4,
        BUR_INCR8  = 3'd5,
        BUR_WRAP16 = 3'd6,
        BUR_INCR16 = 3'd7
    } hburst_e;

    // Beats still to come after the NONSEQ and the first SEQ of a fixed-length burst.
    localparam logic [3:0] REMAIN_16 = 4'd14;
    localparam logic [3:0] REMAIN_8  = 4'd6;
    localparam logic [3:0] REMAIN_4  = 4'd2;

    function automatic logic [3:0] incr_remain(input int beats);
        return (beats >= 2) ? 4'(beats - 2) : 4'd0;
    endfunction

    function automatic int wrap_inc(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/ahb_arb_burst_ctrl.sv
// Burst tracking for one output arbiter: counts the remaining beats of the granted
// burst and limits how often early-terminated INCR bursts may hold arbitration.
module ahb_arb_burst_ctrl
    import ahb_bm_pkg::*;
#(
    parameter int INCR_HOLD_BEATS = 4,
    parameter int EARLY_INCR_MAX  = 1
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    output logic       next_hold
);

    localparam logic [3:0] INCR_REMAIN = incr_remain(INCR_HOLD_BEATS);
    localparam logic       INCR_HOLD   = (INCR_HOLD_BEATS > 1);
    localparam logic [1:0] EARLY_LIMIT = 2'(EARLY_INCR_MAX);

    logic [3:0] burst_remain;
    logic [3:0] next_remain;
    logic       burst_hold;
    logic [1:0] early_cnt;
    logic [1:0] next_early;

    always_comb begin
        next_remain = burst_remain;
        next_hold   = burst_hold;
        if (!HSELM) begin
            next_remain = 4'd0;
            next_hold   = 1'b0;
        end else begin
            case (htrans_e'(HTRANSM))
                TRN_NONSEQ: begin
                    case (hburst_e'(HBURSTM))
                        BUR_INCR16, BUR_WRAP16: begin
                            next_remain = REMAIN_16;
                            next_hold   = 1'b1;
                        end
                        BUR_INCR8, BUR_WRAP8: begin
                            next_remain = REMAIN_8;
                            next_hold   = 1'b1;
                        end
                        BUR_INCR4, BUR_WRAP4: begin
                            next_remain = REMAIN_4;
                            next_hold   = 1'b1;
                        end
                        // Too many back-to-back early-terminated INCRs: let others in.
                        BUR_INCR: begin
                            if (early_cnt == EARLY_LIMIT) begin
                                next_remain = 4'd0;
                                next_hold   = 1'b0;
                            end else begin
                                next_remain = INCR_REMAIN;
                                next_hold   = INCR_HOLD;
                            end
                        end
                        default: begin
                            next_remain = 4'd0;
                            next_hold   = 1'b0;
                        end
                    endcase
                end
                TRN_SEQ: begin
                    if (burst_remain == 4'd0) begin
                        next_remain = 4'd0;
                        next_hold   = 1'b0;
                    end else begin
                        next_remain = burst_remain - 4'd1;
                    end
                end
                TRN_BUSY: begin
                    next_remain = burst_remain;
                    next_hold   = burst_hold;
                end
                default: begin
                    next_remain = 4'd0;
                    next_hold   = 1'b0;
                end
            endcase
        end
    end

    // A NONSEQ arriving while a burst is still held means that burst ended early.
    always_comb begin
        next_early = early_cnt;
        if (!next_hold) begin
            next_early = 2'd0;
        end else if (burst_hold && (htrans_e'(HTRANSM) == TRN_NONSEQ)) begin
            next_early = (early_cnt == 2'd3) ? 2'd3 : early_cnt + 2'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            burst_remain <= 4'd0;
            burst_hold   <= 1'b0;
            early_cnt    <= 2'd0;
        end else if (HREADYM) begin
            burst_remain <= next_remain;
            burst_hold   <= next_hold;
            early_cnt    <= next_early;
        end
    end

endmodule

// File: rtl/ahb_output_arbiter_rr.sv
// Output-stage arbiter for one shared slave port: round-robin over NUM_PORTS input stages,
// holding the grant for locks and bursts. Define AHB_ARB_FIXED_PRIO_EN for lowest-index-wins.
module ahb_output_arbiter_rr
    import ahb_bm_pkg::*;
#(
    parameter  int NUM_PORTS       = 4,
    parameter  int INCR_HOLD_BEATS = 4,
    parameter  int EARLY_INCR_MAX  = 1,
    localparam int PORT_W          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port
);

    logic              next_hold;
    logic [PORT_W-1:0] next_addr;
    logic              next_no_port;
    logic              found;
    logic [PORT_W-1:0] hit_idx;
    logic [PORT_W-1:0] idx_w;
    int                start;
    int                idx;

    ahb_arb_burst_ctrl #(
        .INCR_HOLD_BEATS (INCR_HOLD_BEATS),
        .EARLY_INCR_MAX  (EARLY_INCR_MAX)
    ) u_burst_ctrl (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HREADYM   (HREADYM),
        .HSELM     (HSELM),
        .HTRANSM   (HTRANSM),
        .HBURSTM   (HBURSTM),
        .next_hold (next_hold)
    );

    // Scan every port once in priority order; the index wraps explicitly so a
    // non-power-of-two port count can never yield an out-of-range grant.
    always_comb begin
        found   = 1'b0;
        hit_idx = addr_in_port;
        idx_w   = '0;
        idx     = 0;
`ifdef AHB_ARB_FIXED_PRIO_EN
        start   = 0;
`else
        start   = wrap_inc(int'(addr_in_port), NUM_PORTS);
`endif
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = start + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            idx_w = PORT_W'(idx);
            if (!found && req_port[idx_w]) begin
                found   = 1'b1;
                hit_idx = idx_w;
            end
        end
    end

    always_comb begin
        next_addr    = addr_in_port;
        next_no_port = no_port;
        if (HMASTLOCKM || next_hold) begin
            next_no_port = 1'b0;
        end else if (found) begin
            next_addr    = hit_idx;
            next_no_port = 1'b0;
        end else if (no_port || !HSELM) begin
            next_no_port = 1'b1;
        end else begin
            next_no_port = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port <= '0;
            no_port      <= 1'b1;
        end else if (HREADYM) begin
            addr_in_port <= next_addr;
            no_port      <= next_no_port;
        end
    end

endmodule
